// File: rtl/dmem_pattern_checker_pkg.sv
// Shared definitions for the data-memory pattern checker: FSM state encodings
// and the memory word size.
package dmem_pattern_checker_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        CHK_IDLE   = 2'd0,
        CHK_READ   = 2'd1,
        CHK_DRAIN  = 2'd2,
        CHK_FINISH = 2'd3
    } chk_state_e;

endpackage

// File: rtl/dmem_check_cmp.sv
// Compare stage of the pattern checker: tracks the read returning this cycle,
// counts mismatches (saturating) and captures the first offending word.
module dmem_check_cmp
    import dmem_pattern_checker_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              flush,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] pattern,
    output logic              bad_c,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [ADDR_W-1:0] first_bad_addr,
    output logic [DATA_W-1:0] first_bad_data
);

    logic              valid;
    logic [ADDR_W-1:0] addr_q;

    assign bad_c = valid && (rdata != pattern);

    // valid/addr_q shadow the read issued last cycle, aligned with rdata
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid          <= 1'b0;
            addr_q         <= '0;
            mismatch_count <= '0;
            first_bad_addr <= '0;
            first_bad_data <= '0;
        end else begin
            valid  <= rd_en && !flush;
            addr_q <= rd_addr;
            if (clear) begin
                mismatch_count <= '0;
                first_bad_addr <= '0;
                first_bad_data <= '0;
            end else if (bad_c) begin
                if (mismatch_count != {CNT_W{1'b1}})
                    mismatch_count <= mismatch_count + CNT_W'(1);
                if (mismatch_count == '0) begin
                    first_bad_addr <= addr_q;
                    first_bad_data <= rdata;
                end
            end
        end
    end

endmodule

// File: rtl/dmem_pattern_checker.sv
// Data-memory read-back checker: sweeps a word range and compares against a pattern.
// Define DMEM_CHECK_STOP_ON_FIRST_EN to abort the sweep at the first mismatch.
module dmem_pattern_checker
    import dmem_pattern_checker_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] pattern,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [ADDR_W-1:0] first_bad_addr,
    output logic [DATA_W-1:0] first_bad_data
);

    chk_state_e        state;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] pattern_q;
    logic              clear;
    logic              bad_c;
    logic              stop_hit;

    assign clear = (state == CHK_IDLE) && start;

`ifdef DMEM_CHECK_STOP_ON_FIRST_EN
    assign stop_hit = bad_c;
`else
    assign stop_hit = 1'b0;
`endif

    dmem_check_cmp #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .flush          (stop_hit),
        .rd_en          (mem_rd_en),
        .rd_addr        (mem_addr),
        .rdata          (mem_rdata),
        .pattern        (pattern_q),
        .bad_c          (bad_c),
        .mismatch_count (mismatch_count),
        .first_bad_addr (first_bad_addr),
        .first_bad_data (first_bad_data)
    );

    // Sweep FSM and address generator; done is raised on entry to FINISH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CHK_IDLE;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            remaining <= '0;
            pattern_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                CHK_IDLE: begin
                    if (start) begin
                        pattern_q <= pattern;
                        pass      <= 1'b1;
                        mem_addr  <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
                        remaining <= word_count;
                        if (word_count == '0) begin
                            state <= CHK_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state     <= CHK_READ;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                CHK_READ: begin
                    if (stop_hit || remaining == CNT_W'(1)) begin
                        mem_rd_en <= 1'b0;
                        state     <= CHK_DRAIN;
                    end else begin
                        mem_addr  <= mem_addr + ADDR_W'(WORD_BYTES);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                CHK_DRAIN: begin
                    // A mismatch here in stop mode waits one more cycle so done
                    // always lands two cycles after the offending compare.
                    if (!stop_hit) begin
                        state <= CHK_FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (mismatch_count == '0) && !bad_c;
                    end
                end
                CHK_FINISH: begin
                    state <= CHK_IDLE;
                end
                default: begin
                    state <= CHK_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_pattern_checker.sv
// Directed self-checking bench for dmem_pattern_checker with a byte-array
// memory model behind a one-cycle synchronous read port.
module tb_dmem_pattern_checker;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic [31:0]       pattern = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_count;
    logic [ADDR_W-1:0] first_bad_addr;
    logic [31:0]       first_bad_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] rd_q[$];
    int          done_at;
    int          busy_cnt;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_pattern_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .pattern        (pattern),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_bad_addr (first_bad_addr),
        .first_bad_data (first_bad_data)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int i;
        i = int'(a[7:0]);
        return {mem[(i + 3) & 255], mem[(i + 2) & 255], mem[(i + 1) & 255], mem[i]};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= rd_word(mem_addr);
    end

    task automatic fill(input int a, input int nwords, input logic [31:0] w);
        for (int j = 0; j < nwords; j++) begin
            mem[a + 4*j]     = w[7:0];
            mem[a + 4*j + 1] = w[15:8];
            mem[a + 4*j + 2] = w[23:16];
            mem[a + 4*j + 3] = w[31:24];
        end
    endtask

    // Start a sweep and watch up to 40 cycles; cycle 1 is the one after the start edge.
    task automatic run_sweep(input logic [31:0] b, input logic [15:0] n,
                             input logic [31:0] p, input int second_start);
        rd_q.delete();
        done_at  = -1;
        busy_cnt = 0;
        @(negedge clk);
        base_addr  = b;
        word_count = n;
        pattern    = p;
        start      = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == second_start) begin
                start     = 1'b1;
                base_addr = 32'd100;
            end
            if (mem_rd_en) rd_q.push_back(mem_addr);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_rd_en, busy, done, pass} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: rd_en/busy/done/pass=%b expected 0001", {mem_rd_en, busy, done, pass});
        end
        vectors++;
        if ({mismatch_count, first_bad_addr, first_bad_data, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_results: cnt=%0d addr=%h data=%h mem_addr=%h expected all 0",
                     mismatch_count, first_bad_addr, first_bad_data, mem_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pass();
        fill(8, 4, 32'hDEADBEEF);
        run_sweep(32'd8, 16'd4, 32'hDEADBEEF, 0);
        vectors++;
        if (rd_q.size() != 4) begin
            miscompares++;
            $display("FAIL pass_nreads: got %0d expected 4", rd_q.size());
        end
        for (int j = 0; j < rd_q.size(); j++) begin
            vectors++;
            if (rd_q[j] !== 32'(8 + 4*j)) begin
                miscompares++;
                $display("FAIL pass_addr%0d: got %0d expected %0d", j, rd_q[j], 8 + 4*j);
            end
        end
        vectors++;
        if (done_at != 6) begin
            miscompares++;
            $display("FAIL pass_done_cycle: got %0d expected 6", done_at);
        end
        vectors++;
        if (busy_cnt != 5) begin
            miscompares++;
            $display("FAIL pass_busy_cycles: got %0d expected 5", busy_cnt);
        end
        vectors++;
        if ({pass, mismatch_count, first_bad_addr} !== {1'b1, 16'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL pass_result: pass=%b cnt=%0d addr=%0d expected 1/0/0", pass, mismatch_count, first_bad_addr);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_done_pulse: done=%b one cycle later expected 0", done);
        end
    endtask

    task automatic test_mismatch();
        fill(28, 4, 32'h00007FFF);
        fill(36, 1, 32'h00007FFE);
        run_sweep(32'd28, 16'd4, 32'h00007FFF, 0);
        vectors++;
        if (done_at != 6) begin
            miscompares++;
            $display("FAIL mis_done_cycle: got %0d expected 6", done_at);
        end
        vectors++;
        if ({pass, mismatch_count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL mis_pass_cnt: pass=%b cnt=%0d expected 0/1", pass, mismatch_count);
        end
        vectors++;
        if ({first_bad_addr, first_bad_data} !== {32'd36, 32'h00007FFE}) begin
            miscompares++;
            $display("FAIL mis_first: addr=%0d data=%h expected 36/00007ffe", first_bad_addr, first_bad_data);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        base_addr  = 32'd28;
        word_count = 16'd4;
        pattern    = 32'h0;
        start      = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (mismatch_count !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_mid_precount: cnt=%0d expected 1", mismatch_count);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, mem_rd_en, done, pass, mismatch_count, first_bad_addr} !== {4'b0001, 16'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: busy=%b rd_en=%b done=%b pass=%b cnt=%0d addr=%0d",
                     busy, mem_rd_en, done, pass, mismatch_count, first_bad_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        vectors++;
        if (done_seen != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_no_done: done pulses=%0d busy=%b expected 0/0", done_seen, busy);
        end
        run_sweep(32'd8, 16'd4, 32'hDEADBEEF, 0);
        vectors++;
        if (done_at != 6 || pass !== 1'b1 || rd_q.size() != 4) begin
            miscompares++;
            $display("FAIL rst_mid_rerun: done_at=%0d pass=%b nreads=%0d expected 6/1/4", done_at, pass, rd_q.size());
        end
    endtask

    task automatic test_zero_count();
        run_sweep(32'd24, 16'd0, 32'h12345678, 0);
        vectors++;
        if (rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_nreads: got %0d expected 0", rd_q.size());
        end
        vectors++;
        if (done_at != 1) begin
            miscompares++;
            $display("FAIL zero_done_cycle: got %0d expected 1", done_at);
        end
        vectors++;
        if ({pass, mismatch_count} !== {1'b1, 16'd0}) begin
            miscompares++;
            $display("FAIL zero_result: pass=%b cnt=%0d expected 1/0", pass, mismatch_count);
        end
    endtask

    task automatic test_misaligned_busy_start();
        run_sweep(32'd10, 16'd4, 32'hDEADBEEF, 2);
        vectors++;
        if (rd_q.size() != 4) begin
            miscompares++;
            $display("FAIL mis_al_nreads: got %0d expected 4", rd_q.size());
        end
        for (int j = 0; j < rd_q.size(); j++) begin
            vectors++;
            if (rd_q[j] !== 32'(8 + 4*j)) begin
                miscompares++;
                $display("FAIL mis_al_addr%0d: got %0d expected %0d", j, rd_q[j], 8 + 4*j);
            end
        end
        vectors++;
        if (done_at != 6 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_al_done: done_at=%0d pass=%b expected 6/1", done_at, pass);
        end
    endtask

    task automatic test_all_bad();
        int exp_rd, exp_done, exp_cnt;
`ifdef DMEM_CHECK_STOP_ON_FIRST_EN
        exp_rd = 2; exp_done = 4; exp_cnt = 1;
`else
        exp_rd = 4; exp_done = 6; exp_cnt = 4;
`endif
        fill(24, 4, 32'h0);
        run_sweep(32'd24, 16'd4, 32'hFFFFFFFF, 0);
        vectors++;
        if (rd_q.size() != exp_rd) begin
            miscompares++;
            $display("FAIL bad_nreads: got %0d expected %0d", rd_q.size(), exp_rd);
        end
        vectors++;
        if (done_at != exp_done) begin
            miscompares++;
            $display("FAIL bad_done_cycle: got %0d expected %0d", done_at, exp_done);
        end
        vectors++;
        if ({pass, mismatch_count} !== {1'b0, 16'(exp_cnt)}) begin
            miscompares++;
            $display("FAIL bad_pass_cnt: pass=%b cnt=%0d expected 0/%0d", pass, mismatch_count, exp_cnt);
        end
        vectors++;
        if ({first_bad_addr, first_bad_data} !== {32'd24, 32'd0}) begin
            miscompares++;
            $display("FAIL bad_first: addr=%0d data=%h expected 24/00000000", first_bad_addr, first_bad_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_pass();
        test_mismatch();
        test_reset_mid_sweep();
        test_zero_count();
        test_misaligned_busy_start();
        test_all_bad();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
